// File: rtl/capture_gray_frontend.sv
// -----------------------------------------------------------------------------
// capture_gray_frontend
//
// Front end of the video stitcher. A sequencer FSM captures one frame of
// camera bytes (R,G,B per pixel) into an on-chip frame buffer, replays the
// buffer through an RGB->grayscale converter, streams the gray pixels to the
// downstream memory and then waits for that memory to report completion.
//
// Ports
//   clk         rising-edge clock for all logic
//   rst         synchronous active-high reset
//   start       1-cycle pulse, starts a frame from IDLE
//   clear       buffer wipe in IDLE (one word per cycle), pointer reset otherwise
//   cam_valid   camera byte valid (used only while capturing)
//   cam_data    camera byte, R,G,B order per pixel
//   ds_done     downstream memory finished (used only while draining)
//   cam_enable  camera runs while high
//   gray_data   gray pixel, valid with gray_valid
//   gray_valid  1-cycle strobe per gray pixel
//   ds_enable   downstream memory enable
//   ds_rw       downstream mode: 1 = write, 0 = read
//   busy        FSM not in IDLE
//   frame_done  1-cycle pulse on return to IDLE after a completed frame
// -----------------------------------------------------------------------------
module capture_gray_frontend #(
    parameter int PIX_W = 8,
    parameter int NPIX  = 16,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic             cam_valid,
    input  logic [PIX_W-1:0] cam_data,
    input  logic             ds_done,
    output logic             cam_enable,
    output logic [PIX_W-1:0] gray_data,
    output logic             gray_valid,
    output logic             ds_enable,
    output logic             ds_rw,
    output logic             busy,
    output logic             frame_done
);

    localparam int DEPTH = 3 * NPIX;
    localparam int CNT_W = $clog2(NPIX + 1);
    localparam int SUM_W = 2 * PIX_W;
    // Luma weights, channel 0 = R, 1 = G, 2 = B (they sum to 256).
    localparam logic [23:0] WEIGHTS = {8'd29, 8'd150, 8'd77};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        CONVERT = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t           state_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [1:0]       phase_reg;      // read issue slot: 0..2 read, 3 pause
    logic [1:0]       trip_reg;       // which channel the next valid byte is
    logic [CNT_W-1:0] gray_cnt_reg;
    logic             rd_valid_reg;
    logic [PIX_W-1:0] rd_data_reg;
    logic [PIX_W-1:0] r_reg;
    logic [PIX_W-1:0] g_reg;

    logic             cam_enable_reg;
    logic [PIX_W-1:0] gray_data_reg;
    logic             gray_valid_reg;
    logic             ds_enable_reg;
    logic             ds_rw_reg;
    logic             busy_reg;
    logic             frame_done_reg;

    assign cam_enable = cam_enable_reg;
    assign gray_data  = gray_data_reg;
    assign gray_valid = gray_valid_reg;
    assign ds_enable  = ds_enable_reg;
    assign ds_rw      = ds_rw_reg;
    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;

    // ------------------------------------------------------------------
    // Frame buffer: write port driven by capture or clear sweep, one
    // registered read port addressed by rd_ptr. Contents are never reset.
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] mem [DEPTH];
    logic             mem_we;
    logic [PIX_W-1:0] mem_wdata;

    always_comb begin
        mem_we    = 1'b0;
        mem_wdata = cam_data;
        if (!rst) begin
            if (state_reg == IDLE && clear) begin
                mem_we    = 1'b1;
                mem_wdata = '0;
            end else if (state_reg == CAPTURE && !clear && cam_valid) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_reg] <= mem_wdata;
        end
        rd_data_reg <= mem[rd_ptr_reg];
    end

    // ------------------------------------------------------------------
    // Grayscale arithmetic. The B channel is taken straight from the read
    // register so the pixel is finished in the cycle after B arrives.
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] chan [3];
    logic [SUM_W-1:0] prod [3];
    logic [SUM_W-1:0] gray_sum;
    logic [PIX_W-1:0] gray_calc;

    assign chan[0] = r_reg;
    assign chan[1] = g_reg;
    assign chan[2] = rd_data_reg;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_weight
            assign prod[gi] = SUM_W'(chan[gi]) * SUM_W'(WEIGHTS[gi*8 +: 8]);
        end
    endgenerate

    assign gray_sum  = prod[0] + prod[1] + prod[2];
    assign gray_calc = gray_sum[8 +: PIX_W];

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            phase_reg      <= '0;
            trip_reg       <= '0;
            gray_cnt_reg   <= '0;
            rd_valid_reg   <= 1'b0;
            r_reg          <= '0;
            g_reg          <= '0;
            cam_enable_reg <= 1'b0;
            gray_data_reg  <= '0;
            gray_valid_reg <= 1'b0;
            ds_enable_reg  <= 1'b0;
            ds_rw_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            gray_valid_reg <= 1'b0;
            frame_done_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (clear) begin
                        // Sweep pointer for the buffer wipe.
                        wr_ptr_reg <= (wr_ptr_reg == AW'(DEPTH - 1)) ? '0
                                                                     : wr_ptr_reg + 1'b1;
                    end
                    if (start) begin
                        state_reg      <= CAPTURE;
                        wr_ptr_reg     <= '0;
                        rd_ptr_reg     <= '0;
                        phase_reg      <= '0;
                        trip_reg       <= '0;
                        gray_cnt_reg   <= '0;
                        rd_valid_reg   <= 1'b0;
                        cam_enable_reg <= 1'b1;
                        busy_reg       <= 1'b1;
                    end
                end

                CAPTURE: begin
                    if (clear) begin
                        wr_ptr_reg <= '0;
                        rd_ptr_reg <= '0;
                    end else if (cam_valid) begin
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                        if (wr_ptr_reg == AW'(DEPTH - 1)) begin
                            state_reg      <= CONVERT;
                            cam_enable_reg <= 1'b0;
                            ds_enable_reg  <= 1'b1;
                            ds_rw_reg      <= 1'b1;
                        end
                    end
                end

                CONVERT: begin
                    if (gray_cnt_reg == CNT_W'(NPIX)) begin
                        state_reg    <= DRAIN;
                        ds_rw_reg    <= 1'b0;
                        rd_valid_reg <= 1'b0;
                    end else begin
                        // Read issue: three reads then one pause slot, so
                        // each pixel takes exactly four cycles.
                        if (phase_reg != 2'd3) begin
                            phase_reg <= phase_reg + 1'b1;
                            if (rd_ptr_reg < AW'(DEPTH)) begin
                                rd_valid_reg <= 1'b1;
                                rd_ptr_reg   <= rd_ptr_reg + 1'b1;
                            end else begin
                                rd_valid_reg <= 1'b0;
                            end
                        end else begin
                            phase_reg    <= '0;
                            rd_valid_reg <= 1'b0;
                        end

                        // Byte consumption, one cycle behind the read.
                        if (rd_valid_reg) begin
                            case (trip_reg)
                                2'd0: begin
                                    r_reg    <= rd_data_reg;
                                    trip_reg <= 2'd1;
                                end
                                2'd1: begin
                                    g_reg    <= rd_data_reg;
                                    trip_reg <= 2'd2;
                                end
                                2'd2: begin
                                    gray_data_reg  <= gray_calc;
                                    gray_valid_reg <= 1'b1;
                                    gray_cnt_reg   <= gray_cnt_reg + 1'b1;
                                    trip_reg       <= 2'd0;
                                end
                                default: trip_reg <= 2'd0;
                            endcase
                        end
                    end
                    if (clear) begin
                        wr_ptr_reg <= '0;
                        rd_ptr_reg <= '0;
                    end
                end

                DRAIN: begin
                    if (clear) begin
                        wr_ptr_reg <= '0;
                        rd_ptr_reg <= '0;
                    end
                    if (ds_done) begin
                        state_reg      <= IDLE;
                        ds_enable_reg  <= 1'b0;
                        ds_rw_reg      <= 1'b0;
                        busy_reg       <= 1'b0;
                        frame_done_reg <= 1'b1;
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_capture_gray_frontend.sv
// -----------------------------------------------------------------------------
// tb_capture_gray_frontend
//
// Self-checking bench for capture_gray_frontend. Pixel tables carry the RGB
// input and the expected gray value; the expected value is queued when the
// B byte is driven and compared when gray_valid appears, together with the
// strobe timing relative to entry into CONVERT.
// -----------------------------------------------------------------------------
module tb_capture_gray_frontend;

    localparam int PIX_W = 8;
    localparam int NPIX  = 16;
    localparam int AW    = 6;

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [7:0] exp_gray;
    } pix_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             clear = 1'b0;
    logic             cam_valid = 1'b0;
    logic [PIX_W-1:0] cam_data = '0;
    logic             ds_done = 1'b0;
    logic             cam_enable;
    logic [PIX_W-1:0] gray_data;
    logic             gray_valid;
    logic             ds_enable;
    logic             ds_rw;
    logic             busy;
    logic             frame_done;

    capture_gray_frontend #(
        .PIX_W (PIX_W),
        .NPIX  (NPIX),
        .AW    (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .clear      (clear),
        .cam_valid  (cam_valid),
        .cam_data   (cam_data),
        .ds_done    (ds_done),
        .cam_enable (cam_enable),
        .gray_data  (gray_data),
        .gray_valid (gray_valid),
        .ds_enable  (ds_enable),
        .ds_rw      (ds_rw),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_checks  = 0;
    int         n_fail    = 0;
    logic [7:0] sb_q[$];
    int         conv_edge = 0;
    int         gray_idx  = 0;

    pix_t tbl  [NPIX];
    pix_t flat [NPIX];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: every gray strobe must match the queue head and
    // land exactly 4 cycles after the previous pixel (first: 4 after CONVERT).
    always @(negedge clk) begin
        if (gray_valid) begin
            if (sb_q.size() == 0) begin
                check("gray_unexpected", 32'(gray_data), 32'hFFFF_FFFF);
            end else begin
                logic [7:0] exp_v;
                exp_v = sb_q.pop_front();
                $display("gray pixel %0d: data=%0d expected=%0d cycle=%0d",
                         gray_idx, gray_data, exp_v, cyc);
                check("gray_data", 32'(gray_data), 32'(exp_v));
                check("gray_timing", 32'(cyc), 32'(conv_edge + 4 * (gray_idx + 1)));
                check("gray_ds_rw", 32'(ds_rw), 32'd1);
            end
            gray_idx++;
        end
    end

    task automatic send_byte(input logic [7:0] d, input bit toggle);
        cam_valid = 1'b1;
        cam_data  = d;
        tick();
        conv_edge = cyc;
        cam_valid = 1'b0;
        if (toggle) begin
            cam_data = 8'($urandom);
            ds_done  = 1'b1;      // must be ignored outside DRAIN
            tick();
            ds_done  = 1'b0;
        end
    endtask

    task automatic do_start();
        gray_idx = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("start_cam_enable", 32'(cam_enable), 32'd1);
        check("start_busy", 32'(busy), 32'd1);
    endtask

    task automatic capture(input bit use_tbl, input bit toggle);
        pix_t p;
        for (int i = 0; i < NPIX; i++) begin
            p = use_tbl ? tbl[i] : flat[i];
            send_byte(p.r, toggle);
            send_byte(p.g, toggle);
            sb_q.push_back(p.exp_gray);
            send_byte(p.b, toggle);
        end
        @(negedge clk);
        check("convert_cam_enable", 32'(cam_enable), 32'd0);
        check("convert_ds_enable", 32'(ds_enable), 32'd1);
        check("convert_ds_rw", 32'(ds_rw), 32'd1);
    endtask

    task automatic finish_frame(input bit start_poke);
        int k;
        if (start_poke) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        k = 0;
        while (gray_idx < NPIX && k < 300) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("gray_count", 32'(gray_idx), 32'(NPIX));
        for (int j = 0; j < 10; j++) begin
            tick();
            @(negedge clk);
            check("drain_ds_enable", 32'(ds_enable), 32'd1);
            check("drain_ds_rw", 32'(ds_rw), 32'd0);
            check("drain_busy", 32'(busy), 32'd1);
            check("drain_frame_done", 32'(frame_done), 32'd0);
        end
        ds_done = 1'b1;
        tick();
        ds_done = 1'b0;
        @(negedge clk);
        check("done_frame_done", 32'(frame_done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_ds_enable", 32'(ds_enable), 32'd0);
        check("done_queue_empty", 32'(sb_q.size()), 32'd0);
        $display("frame complete at cycle %0d", cyc);
        tick();
        @(negedge clk);
        check("frame_done_pulse", 32'(frame_done), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < NPIX; i++) flat[i] = '{8'd10, 8'd20, 8'd30, 8'd18};
        tbl[0]  = '{8'd255, 8'd255, 8'd255, 8'd255};
        tbl[1]  = '{8'd0,   8'd0,   8'd0,   8'd0};
        tbl[2]  = '{8'd255, 8'd0,   8'd0,   8'd76};
        tbl[3]  = '{8'd0,   8'd255, 8'd0,   8'd149};
        tbl[4]  = '{8'd0,   8'd0,   8'd255, 8'd28};
        tbl[5]  = '{8'd10,  8'd20,  8'd30,  8'd18};
        tbl[6]  = '{8'd100, 8'd100, 8'd100, 8'd100};
        tbl[7]  = '{8'd1,   8'd2,   8'd3,   8'd1};
        tbl[8]  = '{8'd200, 8'd100, 8'd50,  8'd124};
        tbl[9]  = '{8'd128, 8'd128, 8'd128, 8'd128};
        tbl[10] = '{8'd50,  8'd60,  8'd70,  8'd58};
        tbl[11] = '{8'd0,   8'd0,   8'd1,   8'd0};
        tbl[12] = '{8'd255, 8'd255, 8'd0,   8'd226};
        tbl[13] = '{8'd0,   8'd255, 8'd255, 8'd178};
        tbl[14] = '{8'd255, 8'd0,   8'd255, 8'd105};
        tbl[15] = '{8'd30,  8'd20,  8'd10,  8'd21};

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("reset_cam_enable", 32'(cam_enable), 32'd0);
        check("reset_gray_valid", 32'(gray_valid), 32'd0);
        check("reset_gray_data", 32'(gray_data), 32'd0);
        check("reset_ds_enable", 32'(ds_enable), 32'd0);
        check("reset_ds_rw", 32'(ds_rw), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_frame_done", 32'(frame_done), 32'd0);
        rst = 1'b0;
        tick();

        // Frame 1: uniform (10,20,30)
        $display("frame 1: uniform pixels");
        do_start();
        capture(1'b0, 1'b0);
        finish_frame(1'b0);

        // Clear sweep in IDLE moves wr_ptr; start must restart from 0.
        clear = 1'b1;
        repeat (5) tick();
        clear = 1'b0;

        // Frame 2: pixel table
        $display("frame 2: pixel table");
        do_start();
        capture(1'b1, 1'b0);
        finish_frame(1'b0);

        // Frame 3: gaps in cam_valid, ds_done noise, start poke in CONVERT
        $display("frame 3: gapped capture, start ignored in CONVERT");
        do_start();
        capture(1'b1, 1'b1);
        finish_frame(1'b1);

        // Frame 4: clear mid-CAPTURE restarts the write pointer; the byte
        // presented together with clear must not be stored.
        $display("frame 4: clear during capture");
        do_start();
        for (int i = 0; i < 6; i++) send_byte(8'd255, 1'b0);
        clear     = 1'b1;
        cam_valid = 1'b1;
        cam_data  = 8'd255;
        tick();
        clear     = 1'b0;
        cam_valid = 1'b0;
        capture(1'b0, 1'b0);
        finish_frame(1'b0);

        // Reset in the middle of CONVERT
        $display("frame 5: reset during convert");
        do_start();
        capture(1'b1, 1'b0);
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb_q.delete();
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ds_enable", 32'(ds_enable), 32'd0);
        check("midrst_ds_rw", 32'(ds_rw), 32'd0);
        check("midrst_cam_enable", 32'(cam_enable), 32'd0);
        check("midrst_gray_valid", 32'(gray_valid), 32'd0);
        for (int j = 0; j < 4; j++) begin
            tick();
            @(negedge clk);
            check("midrst_no_frame_done", 32'(frame_done), 32'd0);
            check("midrst_idle", 32'(busy), 32'd0);
        end

        // Frame 6: fresh capture after the abort
        $display("frame 6: recapture after reset");
        do_start();
        capture(1'b1, 1'b0);
        finish_frame(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
